// File: rtl/avg_sink_buffer.sv
// avg_sink_buffer
//   Decimating show-ahead FIFO that sits behind the smoothing stage. Keeps one
//   of every (decim+1) upstream samples and buffers the kept samples for a
//   downstream consumer. A kept sample that finds the FIFO full (with no pop
//   in the same cycle) is dropped and latches the sticky overflow flag.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_ready   upstream sample strobe (smoothing stage ready output)
//   in_data    upstream smoothed sample, DW bits
//   decim      decimation control, keep 1 of every (decim+1) samples
//   out_valid  FIFO head word valid (level != 0)
//   out_data   FIFO head word, show-ahead, fully registered
//   out_ready  downstream accepts the head word
//   overflow   sticky: a kept sample was dropped; cleared only by reset
//   level      FIFO occupancy, 0..DEPTH
module avg_sink_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic [3:0]               decim,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
  localparam logic [AW:0]   ONE_LEVEL  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   level_q;
  logic [3:0]    dcnt;
  logic [DW-1:0] head;
  logic [DW-1:0] head_next;
  logic          overflow_q;

  logic keep;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign keep       = in_ready && (dcnt == 4'd0);
  assign pop        = (level_q != '0) && out_ready;
  assign full       = (level_q == FULL_LEVEL);
  assign push       = keep && (!full || pop);
  assign drop       = keep && full && !pop;
  assign rd_ptr_inc = rd_ptr + PTR_ONE;

  // The head register mirrors mem[rd_ptr] one edge ahead so out_data is a
  // plain flop: reset-clean and free of any path from in_data.
  always_comb begin
    head_next = head;
    if (pop) begin
      if (level_q == ONE_LEVEL) begin
        if (push) head_next = in_data;
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end else if (push && (level_q == '0)) begin
      head_next = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt <= 4'd0;
    end else if (in_ready) begin
      // decim is live; lowering it below dcnt wraps on the next sample.
      dcnt <= (dcnt >= decim) ? 4'd0 : dcnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      head       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   level_q <= level_q + ONE_LEVEL;
        2'b01:   level_q <= level_q - ONE_LEVEL;
        default: level_q <= level_q;
      endcase
      head <= head_next;
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; a word is only visible after a write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = head;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_avg_sink_buffer.sv
module tb_avg_sink_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_ready = 1'b0;
  logic [15:0] in_data = '0;
  logic [3:0]  decim = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        overflow;
  logic [3:0]  level;

  int n_vec  = 0;
  int n_miss = 0;
  logic [15:0] sb[$];

  avg_sink_buffer #(.DEPTH(8), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .decim     (decim),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word is compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_out: got %0h expected none", out_data);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [15:0] d, input bit kept);
    in_ready = 1'b1;
    in_data  = d;
    if (kept) sb.push_back(d);
    tick();
    in_ready = 1'b0;
  endtask

  task automatic do_reset();
    in_ready  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #2;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // decim=0 pass-through, one cycle latency
    do_reset();
    decim = 4'd0;
    out_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      sample(16'(i), 1'b1);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_level", 32'(level), 32'd1);
    end
    tick();
    check("t1_level_end", 32'(level), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // decim=2, idle gap, resume
    do_reset();
    decim = 4'd2;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) sample(16'(i), (i % 3) == 0);
    repeat (5) tick();
    sample(16'd12, 1'b1);
    sample(16'd13, 1'b0);
    sample(16'd14, 1'b0);
    repeat (3) tick();
    check("t2_sb_empty", 32'(sb.size()), 32'd0);
    check("t2_level", 32'(level), 32'd0);

    // overflow while full, then drain
    do_reset();
    decim = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sample(16'hA0 + 16'(i), 1'b1);
      check("t3_head_stable", 32'(out_data), 32'hA0);
    end
    check("t3_level8", 32'(level), 32'd8);
    check("t3_ovf_pre", 32'(overflow), 32'd0);
    sample(16'hA8, 1'b0);
    check("t3_level_a8", 32'(level), 32'd8);
    check("t3_ovf_a8", 32'(overflow), 32'd1);
    sample(16'hA9, 1'b0);
    check("t3_head_a9", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    repeat (8) tick();
    check("t3_level_drained", 32'(level), 32'd0);
    check("t3_ovf_sticky", 32'(overflow), 32'd1);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // push and pop on a full FIFO
    do_reset();
    decim = 4'd0;
    for (int i = 0; i < 8; i++) sample(16'hB0 + 16'(i), 1'b1);
    out_ready = 1'b1;
    sample(16'hB8, 1'b1);
    check("t4_level", 32'(level), 32'd8);
    check("t4_ovf", 32'(overflow), 32'd0);
    repeat (9) tick();
    check("t4_level_drained", 32'(level), 32'd0);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // decim lowered below dcnt
    do_reset();
    decim = 4'd7;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) sample(16'hC00 + 16'(i), i == 0);
    decim = 4'd1;
    for (int i = 5; i <= 10; i++) sample(16'hC00 + 16'(i), (i % 2) == 0);
    repeat (2) tick();
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // async reset with level=5 and overflow set
    do_reset();
    decim = 4'd0;
    for (int i = 0; i < 8; i++) sample(16'hD0 + 16'(i), 1'b1);
    sample(16'hD8, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t6_level5", 32'(level), 32'd5);
    check("t6_ovf", 32'(overflow), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_level", 32'(level), 32'd0);
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_ovf", 32'(overflow), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    sample(16'hE0, 1'b1);
    check("t6_first_valid", 32'(out_valid), 32'd1);
    repeat (2) tick();
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/avg_sink_buffer.md
AVG_SINK_BUFFER -- requirements
Module: avg_sink_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in 16-bit words; legal values are powers of two from 2 to 64.
REQ-002 Parameter DW, default 16, sample width; it matches the smoothing stage output width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_ready  input  1  upstream smoothing stage "sample valid" flag (its ready output).
REQ-006 in_data  input  DW  upstream smoothed sample (its dout output).
REQ-007 decim  input  4  decimation control; keep 1 of every (decim+1) samples.
REQ-008 out_valid  output  1  FIFO head word valid.
REQ-009 out_data  output  DW  FIFO head word (show-ahead).
REQ-010 out_ready  input  1  downstream consumer accepts the head word.
REQ-011 overflow  output  1  sticky flag: a kept sample was dropped.
REQ-012 level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-013 Input sample: any cycle with in_ready=1. Cycles with in_ready=0 are ignored entirely; dcnt holds.
REQ-014 Decimation counter dcnt: 4 bits. On each input sample it advances to dcnt+1, or to 0 when dcnt>=decim.
REQ-015 A sample is "kept" when dcnt==0 in its cycle; decim=0 keeps every sample.
REQ-016 decim is sampled every cycle, not latched. If decim is lowered below the current dcnt, the next input sample wraps dcnt to 0, and that sample is not kept.
REQ-017 Push: a kept sample is written into the FIFO when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-018 Drop: a kept sample with level==DEPTH and no same-cycle pop is discarded, and overflow is set to 1 on the next edge.
REQ-019 overflow clears only on reset.
REQ-020 Pop: occurs when out_valid=1 and out_ready=1; the head advances on that edge.
REQ-021 out_ready while out_valid=0 has no effect.
REQ-022 out_valid = (level!=0), registered-state derived; there is no combinational path from in_ready or in_data to out_valid or out_data.
REQ-023 Latency: a sample pushed into an empty FIFO at edge N appears on out_data with out_valid=1 immediately after edge N, i.e. visible in cycle N+1.
REQ-024 Simultaneous push and pop at 0<level<DEPTH: level unchanged, order preserved.
REQ-025 Simultaneous push and pop at level==DEPTH: pop happens, push is accepted, level stays DEPTH, no overflow.
REQ-026 Simultaneous push and pop at level==0 is impossible: pop requires out_valid.
REQ-027 Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 level is tracked by a separate counter, or by extended pointers, and never exceeds DEPTH.
REQ-029 out_data is stable while out_valid=1 and out_ready=0.
REQ-030 When out_valid=0, out_data holds the last head value; this value is don't-care for checking.

Reset
REQ-031 Reset asserted at any time, including mid-stream or while full, forces: dcnt=0, both pointers=0, level=0, out_valid=0, overflow=0, out_data=0.
REQ-032 FIFO storage contents are not reset and are not observable until rewritten.
REQ-033 The first in_ready=1 cycle after reset deassertion is sample index 0 and is kept.

Verification
REQ-034 decim=0, out_ready=1, in_ready=1 with in_data=1,2,3,...,20 -> out_data=1..20 in order, each one cycle after its input; level never exceeds 1; overflow=0.
REQ-035 decim=2, out_ready=1, in_ready=1 with data 0..11 -> outputs 0,3,6,9 only. Then hold in_ready=0 for 5 cycles and resume with data 12,13,14 -> output 12; dcnt resumes from where it stopped.
REQ-036 DEPTH=8, decim=0, out_ready=0, 10 samples A0..A9 -> level=8 and overflow=1 after A8. Then out_ready=1 -> outputs A0..A7 exactly, and overflow stays 1.
REQ-037 Full FIFO, decim=0, out_ready=1 and a kept sample in the same cycle -> level stays 8, overflow=0, and the new word emerges after the 8 prior words.
REQ-038 decim changed from 7 to 1 while dcnt=5 -> the next sample is not kept; the one after it is kept; thereafter every 2nd sample is kept.
REQ-039 Reset pulse asserted mid-edge with level=5 and overflow=1 -> out_valid, level and overflow go to 0 immediately (asynchronous). The first post-reset in_ready sample is output.
